// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds 8 micro-ops until both operands are captured, then issues one per cycle.
// Latency: a dispatch with ready operands at edge N issues at edge N+1; a wakeup at edge N issues at N+1 at the earliest.
// Backpressure: rs_full asserts when every entry is busy (dispatch then dropped); rdy_in low freezes everything.
module alu_reservation_station #(
    parameter int RS_SIZE_BIT  = 3,
    parameter int ROB_SIZE_BIT = 4,
    parameter int RS_TYPE_BIT  = 6
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear,
    input  logic                    dispatch_valid,
    input  logic [RS_TYPE_BIT-1:0]  dispatch_op,
    input  logic [ROB_SIZE_BIT-1:0] dispatch_rob_idx,
    input  logic [31:0]             dispatch_vj,
    input  logic [31:0]             dispatch_vk,
    input  logic                    dispatch_qj_pend,
    input  logic                    dispatch_qk_pend,
    input  logic [ROB_SIZE_BIT-1:0] dispatch_qj,
    input  logic [ROB_SIZE_BIT-1:0] dispatch_qk,
    input  logic                    cdb_alu_ready,
    input  logic [ROB_SIZE_BIT-1:0] cdb_alu_rob_idx,
    input  logic [31:0]             cdb_alu_result,
    input  logic                    cdb_lsb_ready,
    input  logic [ROB_SIZE_BIT-1:0] cdb_lsb_rob_idx,
    input  logic [31:0]             cdb_lsb_result,
    output logic                    rs_full,
    output logic                    alu_valid,
    output logic [31:0]             alu_r1,
    output logic [31:0]             alu_r2,
    output logic [ROB_SIZE_BIT-1:0] alu_rob_idx,
    output logic [RS_TYPE_BIT-1:0]  alu_op
);
    localparam int RS_SIZE = 1 << RS_SIZE_BIT;

    typedef struct packed {
        logic [RS_TYPE_BIT-1:0]  op;
        logic [ROB_SIZE_BIT-1:0] rob_idx;
        logic [31:0]             vj;
        logic [31:0]             vk;
        logic                    qj_pend;
        logic [ROB_SIZE_BIT-1:0] qj;
        logic                    qk_pend;
        logic [ROB_SIZE_BIT-1:0] qk;
    } entry_t;

    entry_t                 ent [RS_SIZE];
    logic [RS_SIZE-1:0]     busy;
    entry_t                 disp_ent;
    logic [RS_SIZE_BIT-1:0] free_idx;
    logic                   has_free;
    logic [RS_SIZE_BIT-1:0] issue_idx;
    logic                   has_issue;

    assign rs_full = &busy;

    // Priority encoders scan downward so the lowest index wins.
    always_comb begin
        free_idx  = '0;
        has_free  = 1'b0;
        issue_idx = '0;
        has_issue = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = RS_SIZE_BIT'(i);
                has_free = 1'b1;
            end
            if (busy[i] && !ent[i].qj_pend && !ent[i].qk_pend) begin
                issue_idx = RS_SIZE_BIT'(i);
                has_issue = 1'b1;
            end
        end
    end

    // Same-cycle bypass of a broadcast into the entry being dispatched; ALU bus has priority.
    always_comb begin
        disp_ent = '{op: dispatch_op, rob_idx: dispatch_rob_idx,
                     vj: dispatch_vj, vk: dispatch_vk,
                     qj_pend: dispatch_qj_pend, qj: dispatch_qj,
                     qk_pend: dispatch_qk_pend, qk: dispatch_qk};
        if (dispatch_qj_pend) begin
            if (cdb_alu_ready && cdb_alu_rob_idx == dispatch_qj) begin
                disp_ent.vj      = cdb_alu_result;
                disp_ent.qj_pend = 1'b0;
            end else if (cdb_lsb_ready && cdb_lsb_rob_idx == dispatch_qj) begin
                disp_ent.vj      = cdb_lsb_result;
                disp_ent.qj_pend = 1'b0;
            end
        end
        if (dispatch_qk_pend) begin
            if (cdb_alu_ready && cdb_alu_rob_idx == dispatch_qk) begin
                disp_ent.vk      = cdb_alu_result;
                disp_ent.qk_pend = 1'b0;
            end else if (cdb_lsb_ready && cdb_lsb_rob_idx == dispatch_qk) begin
                disp_ent.vk      = cdb_lsb_result;
                disp_ent.qk_pend = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy        <= '0;
            alu_valid   <= 1'b0;
            alu_r1      <= '0;
            alu_r2      <= '0;
            alu_rob_idx <= '0;
            alu_op      <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                busy      <= '0;
                alu_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && ent[i].qj_pend) begin
                        if (cdb_alu_ready && cdb_alu_rob_idx == ent[i].qj) begin
                            ent[i].vj      <= cdb_alu_result;
                            ent[i].qj_pend <= 1'b0;
                        end else if (cdb_lsb_ready && cdb_lsb_rob_idx == ent[i].qj) begin
                            ent[i].vj      <= cdb_lsb_result;
                            ent[i].qj_pend <= 1'b0;
                        end
                    end
                    if (busy[i] && ent[i].qk_pend) begin
                        if (cdb_alu_ready && cdb_alu_rob_idx == ent[i].qk) begin
                            ent[i].vk      <= cdb_alu_result;
                            ent[i].qk_pend <= 1'b0;
                        end else if (cdb_lsb_ready && cdb_lsb_rob_idx == ent[i].qk) begin
                            ent[i].vk      <= cdb_lsb_result;
                            ent[i].qk_pend <= 1'b0;
                        end
                    end
                end
                alu_valid <= has_issue;
                if (has_issue) begin
                    alu_r1           <= ent[issue_idx].vj;
                    alu_r2           <= ent[issue_idx].vk;
                    alu_rob_idx      <= ent[issue_idx].rob_idx;
                    alu_op           <= ent[issue_idx].op;
                    busy[issue_idx]  <= 1'b0;
                end
                // Free slot comes from pre-edge busy, so it never collides with the issuing entry.
                if (dispatch_valid && has_free) begin
                    ent[free_idx]  <= disp_ent;
                    busy[free_idx] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: hand-computed vectors checked with immediate assertions.
module tb_alu_reservation_station;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear;
    logic        dispatch_valid;
    logic [5:0]  dispatch_op;
    logic [3:0]  dispatch_rob_idx;
    logic [31:0] dispatch_vj, dispatch_vk;
    logic        dispatch_qj_pend, dispatch_qk_pend;
    logic [3:0]  dispatch_qj, dispatch_qk;
    logic        cdb_alu_ready;
    logic [3:0]  cdb_alu_rob_idx;
    logic [31:0] cdb_alu_result;
    logic        cdb_lsb_ready;
    logic [3:0]  cdb_lsb_rob_idx;
    logic [31:0] cdb_lsb_result;
    logic        rs_full, alu_valid;
    logic [31:0] alu_r1, alu_r2;
    logic [3:0]  alu_rob_idx;
    logic [5:0]  alu_op;

    int vectors = 0;
    int errors  = 0;

    alu_reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op),
        .dispatch_rob_idx(dispatch_rob_idx), .dispatch_vj(dispatch_vj),
        .dispatch_vk(dispatch_vk), .dispatch_qj_pend(dispatch_qj_pend),
        .dispatch_qk_pend(dispatch_qk_pend), .dispatch_qj(dispatch_qj),
        .dispatch_qk(dispatch_qk), .cdb_alu_ready(cdb_alu_ready),
        .cdb_alu_rob_idx(cdb_alu_rob_idx), .cdb_alu_result(cdb_alu_result),
        .cdb_lsb_ready(cdb_lsb_ready), .cdb_lsb_rob_idx(cdb_lsb_rob_idx),
        .cdb_lsb_result(cdb_lsb_result), .rs_full(rs_full),
        .alu_valid(alu_valid), .alu_r1(alu_r1), .alu_r2(alu_r2),
        .alu_rob_idx(alu_rob_idx), .alu_op(alu_op)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        clear = 0; dispatch_valid = 0; dispatch_op = 0; dispatch_rob_idx = 0;
        dispatch_vj = 0; dispatch_vk = 0; dispatch_qj_pend = 0; dispatch_qk_pend = 0;
        dispatch_qj = 0; dispatch_qk = 0;
        cdb_alu_ready = 0; cdb_alu_rob_idx = 0; cdb_alu_result = 0;
        cdb_lsb_ready = 0; cdb_lsb_rob_idx = 0; cdb_lsb_result = 0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [3:0] rob,
                        input logic [31:0] vj, input logic qjp, input logic [3:0] qj,
                        input logic [31:0] vk, input logic qkp, input logic [3:0] qk);
        dispatch_valid = 1; dispatch_op = op; dispatch_rob_idx = rob;
        dispatch_vj = vj; dispatch_qj_pend = qjp; dispatch_qj = qj;
        dispatch_vk = vk; dispatch_qk_pend = qkp; dispatch_qk = qk;
    endtask

    initial begin
        idle();
        rst_in = 0; rdy_in = 1;
        tick(); tick();
        chk("rst_valid", 32'(alu_valid), 0);
        chk("rst_r1", alu_r1, 0);
        chk("rst_r2", alu_r2, 0);
        chk("rst_rob", 32'(alu_rob_idx), 0);
        chk("rst_op", 32'(alu_op), 0);
        chk("rst_full", 32'(rs_full), 0);

        // ADD with both operands ready
        rst_in = 1;
        disp(6'b010000, 4'd3, 32'd5, 0, 0, 32'd7, 0, 0);
        tick(); idle();
        chk("add_e0_valid", 32'(alu_valid), 0);
        tick();
        chk("add_valid", 32'(alu_valid), 1);
        chk("add_r1", alu_r1, 5);
        chk("add_r2", alu_r2, 7);
        chk("add_rob", 32'(alu_rob_idx), 3);
        chk("add_op", 32'(alu_op), 32'b010000);
        tick();
        chk("add_e2_valid", 32'(alu_valid), 0);
        chk("add_e2_r1_hold", alu_r1, 5);

        // SUB waiting on tag 2, woken by ALU broadcast
        disp(6'b011000, 4'd4, 32'd0, 1, 4'd2, 32'd1, 0, 0);
        tick(); idle();
        tick();
        chk("sub_wait1", 32'(alu_valid), 0);
        tick();
        chk("sub_wait2", 32'(alu_valid), 0);
        cdb_alu_ready = 1; cdb_alu_rob_idx = 4'd2; cdb_alu_result = 32'h10;
        tick(); idle();
        chk("sub_wake_edge", 32'(alu_valid), 0);
        tick();
        chk("sub_valid", 32'(alu_valid), 1);
        chk("sub_r1", alu_r1, 32'h10);
        chk("sub_r2", alu_r2, 1);
        chk("sub_rob", 32'(alu_rob_idx), 4);
        chk("sub_op", 32'(alu_op), 32'b011000);

        // Same-cycle bypass from the LSB bus
        disp(6'b010001, 4'd5, 32'd3, 0, 0, 32'd0, 1, 4'd6);
        cdb_lsb_ready = 1; cdb_lsb_rob_idx = 4'd6; cdb_lsb_result = 32'hABCD;
        tick(); idle();
        chk("byp_e0_valid", 32'(alu_valid), 0);
        tick();
        chk("byp_valid", 32'(alu_valid), 1);
        chk("byp_r1", alu_r1, 3);
        chk("byp_r2", alu_r2, 32'hABCD);
        chk("byp_rob", 32'(alu_rob_idx), 5);

        // Both buses carry the same tag: ALU value must be taken
        disp(6'b110000, 4'd6, 32'd0, 1, 4'd7, 32'd9, 0, 0);
        cdb_alu_ready = 1; cdb_alu_rob_idx = 4'd7; cdb_alu_result = 32'h111;
        cdb_lsb_ready = 1; cdb_lsb_rob_idx = 4'd7; cdb_lsb_result = 32'h222;
        tick(); idle();
        tick();
        chk("prio_valid", 32'(alu_valid), 1);
        chk("prio_r1", alu_r1, 32'h111);
        chk("prio_op", 32'(alu_op), 32'b110000);

        // Fill all 8 entries pending on tag 9
        for (int i = 0; i < 8; i++) begin
            disp(6'b010000, 4'(i), 32'd0, 1, 4'd9, 32'h100 + 32'(i), 0, 0);
            tick();
        end
        idle();
        chk("fill_full", 32'(rs_full), 1);
        disp(6'b010000, 4'd15, 32'hDEAD, 0, 0, 32'hBEEF, 0, 0);
        tick(); idle();
        chk("drop_full", 32'(rs_full), 1);
        chk("drop_valid", 32'(alu_valid), 0);
        cdb_alu_ready = 1; cdb_alu_rob_idx = 4'd9; cdb_alu_result = 32'h900;
        tick(); idle();
        chk("drain_wake_edge", 32'(alu_valid), 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("drain%0d_valid", k), 32'(alu_valid), 1);
            chk($sformatf("drain%0d_rob", k), 32'(alu_rob_idx), 32'(k));
            chk($sformatf("drain%0d_r1", k), alu_r1, 32'h900);
            chk($sformatf("drain%0d_r2", k), alu_r2, 32'h100 + 32'(k));
            if (k == 0) chk("drain_full_after_first", 32'(rs_full), 0);
        end
        tick();
        chk("drain_done_valid", 32'(alu_valid), 0);

        // rdy_in low freezes outputs and ignores dispatch
        disp(6'b010000, 4'd2, 32'h42, 0, 0, 32'h43, 0, 0);
        tick();
        disp(6'b010000, 4'd10, 32'h52, 0, 0, 32'h53, 0, 0);
        tick();
        chk("frz_pre_valid", 32'(alu_valid), 1);
        chk("frz_pre_rob", 32'(alu_rob_idx), 2);
        disp(6'b010000, 4'd12, 32'h62, 0, 0, 32'h63, 0, 0);
        rdy_in = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("frz%0d_valid", c), 32'(alu_valid), 1);
            chk($sformatf("frz%0d_rob", c), 32'(alu_rob_idx), 2);
            chk($sformatf("frz%0d_r1", c), alu_r1, 32'h42);
        end
        idle();
        rdy_in = 1;
        tick();
        chk("thaw_valid", 32'(alu_valid), 1);
        chk("thaw_rob", 32'(alu_rob_idx), 10);
        chk("thaw_r1", alu_r1, 32'h52);
        tick();
        chk("thaw_ignored_disp", 32'(alu_valid), 0);

        // Clear with 3 resident entries plus a same-cycle dispatch
        for (int i = 0; i < 3; i++) begin
            disp(6'b010000, 4'(i + 1), 32'd0, 1, 4'd12, 32'd0, 0, 0);
            tick();
        end
        idle();
        disp(6'b010000, 4'd13, 32'h1, 0, 0, 32'h2, 0, 0);
        clear = 1;
        tick(); idle();
        chk("clr_full", 32'(rs_full), 0);
        chk("clr_valid", 32'(alu_valid), 0);
        cdb_alu_ready = 1; cdb_alu_rob_idx = 4'd12; cdb_alu_result = 32'hC;
        tick(); idle();
        tick();
        chk("clr_no_stale_issue", 32'(alu_valid), 0);
        disp(6'b010000, 4'd9, 32'h77, 0, 0, 32'h88, 0, 0);
        tick(); idle();
        tick();
        chk("post_clr_valid", 32'(alu_valid), 1);
        chk("post_clr_rob", 32'(alu_rob_idx), 9);
        chk("post_clr_r2", alu_r2, 32'h88);

        // Reset mid-stream overrides a pending dispatch and issue
        disp(6'b010000, 4'd11, 32'h55, 0, 0, 32'h56, 0, 0);
        tick();
        disp(6'b010000, 4'd14, 32'h65, 0, 0, 32'h66, 0, 0);
        rst_in = 0;
        tick(); idle();
        chk("mrst_valid", 32'(alu_valid), 0);
        chk("mrst_r1", alu_r1, 0);
        chk("mrst_r2", alu_r2, 0);
        chk("mrst_rob", 32'(alu_rob_idx), 0);
        chk("mrst_op", 32'(alu_op), 0);
        chk("mrst_full", 32'(rs_full), 0);
        rst_in = 1;
        tick();
        chk("mrst_after_valid", 32'(alu_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
